pipeline_id_ex: RTL and testbench
=================================

PIPELINE_ID_EX -- requirements
Module: pipeline_id_ex

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 8, operand/PC/address width.
- REG_AW, 2, register-index width.
- ALU_SEL_W, 4, ALU select width.
- CNT_W, 16, performance-counter width.

REQ-002 Ports (name, direction, width, meaning); clk and rst first; rst is asynchronous, active-high:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold request from downstream.
- flush  in  1  kill request; a bubble is loaded.
- id_valid  in  1  the ID slot holds a real instruction.
- A / B  in  DATA_W each  operands.
- PC2  in  DATA_W  return PC.
- ea  in  DATA_W  effective address/immediate.
- ra / rb  in  REG_AW each  source indices.
- rd  in  REG_AW  destination index.
- ra_used / rb_used  in  1 each  the source is actually read.
- ex_ctrl  in  EX_W  {lr_en, brx, alu_sel, br_sel}.
- mem_ctrl  in  3  {wr_en, imm_sel, read}.
- wb_ctrl  in  2  {wb_sel, reg_en}.
- cnt_clr  in  1  synchronous counter clear.
- *_out  out  same widths  registered copies of all payload and control inputs above (A..wb_ctrl, excluding ra_used/rb_used).
- valid_out  out  1  the EX slot holds a real instruction.
- hazard  out  1  load-use hazard; upstream must hold PC/IF/ID.
- stall_cnt / bubble_cnt  out  CNT_W each  performance counters.

Function
REQ-003 Next-state priority per clock: flush > stall > hazard > load.
REQ-004 Flush: valid_out <= 0, and every control output and payload output <= 0 on the next edge.
REQ-005 Stall without flush: every output register holds its value, including valid_out.
REQ-006 hazard is combinational and equals valid_out & mem_ctrl_out.read & wb_ctrl_out.reg_en & id_valid & ((ra_used & ra==rd_out) | (rb_used & rb==rd_out)).
REQ-007 hazard=1 with no stall and no flush: a bubble is loaded (same as REQ-004) and the ID contents are not captured; hazard deasserts the next cycle because valid_out=0.
REQ-008 Load (no flush, stall or hazard): all outputs take their inputs with 1-cycle latency, and valid_out <= id_valid.
REQ-009 When id_valid=0 on a load, control outputs are forced to 0; payload outputs are don't-care but shall be 0.
REQ-010 stall_cnt increments on every cycle with stall=1; bubble_cnt increments on every cycle a bubble is loaded by flush or hazard.
REQ-011 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-012 cnt_clr zeroes both counters on the next edge and overrides any increment in the same cycle; cnt_clr does not affect pipeline contents.
REQ-013 The hazard comparison uses the registered rd_out and the registered control outputs, not the incoming ID values.

Reset
REQ-014 rst=1 asynchronously drives every output register, valid_out and both counters to 0, independent of clk.
REQ-015 hazard therefore reads 0 while rst=1.
REQ-016 On the first rising edge after rst deasserts, normal REQ-003 priority applies.
REQ-017 rst asserted mid-stall or mid-hazard discards the held instruction.

Structure
REQ-018 A shared package holds:
- the ex_ctrl, mem_ctrl and wb_ctrl field offsets and the EX_W constant;
- packed struct typedefs for the three control bundles;
- the BUBBLE constant (all-zero control).
REQ-019 One sub-module, pipeline_hazard_unit, contains the purely combinational REQ-006 logic for reuse by later stage registers.

Verification
REQ-020 Directed scenarios:
- Load/latency: reset, then id_valid=1, A=0x5A, alu_sel=0x3 -> A_out=0x5A, alu_sel_out=0x3, valid_out=1 one edge later.
- Stall hold: outputs loaded, then stall=1 for 3 cycles with new inputs -> outputs unchanged, stall_cnt=3.
- Load-use: EX holds read=1, reg_en=1, rd_out=2; ID has ra=2, ra_used=1 -> hazard=1; next edge valid_out=0, bubble_cnt=1, hazard=0.
- No false hazard: same as the load-use case but ra_used=0, or read=0 -> hazard=0 and the instruction loads normally.
- Flush beats stall: flush=1 and stall=1 together -> all control outputs 0, valid_out=0, bubble_cnt+1, stall_cnt+1.
- Async reset and saturation: rst pulsed between edges -> outputs 0 immediately. Separately, with CNT_W=2, 5 stall cycles -> stall_cnt=3; cnt_clr -> 0.

Source files
------------

// File: rtl/pipeline_id_ex_pkg.sv
// Shared control-bundle layout for the ID/EX stage register and its hazard unit.
package pipeline_id_ex_pkg;

  localparam int unsigned ALU_SEL_W_PKG = 4;
  localparam int unsigned BR_SEL_W      = 2;

  // Bit offsets inside ex_ctrl = {lr_en, brx, alu_sel, br_sel}
  localparam int unsigned EX_BR_SEL_LSB  = 0;
  localparam int unsigned EX_ALU_SEL_LSB = EX_BR_SEL_LSB + BR_SEL_W;
  localparam int unsigned EX_BRX_BIT     = EX_ALU_SEL_LSB + ALU_SEL_W_PKG;
  localparam int unsigned EX_LR_EN_BIT   = EX_BRX_BIT + 1;

  // Bit offsets inside mem_ctrl = {wr_en, imm_sel, read} and wb_ctrl = {wb_sel, reg_en}
  localparam int unsigned MEM_READ_BIT    = 0;
  localparam int unsigned MEM_IMM_SEL_BIT = 1;
  localparam int unsigned MEM_WR_EN_BIT   = 2;
  localparam int unsigned WB_REG_EN_BIT   = 0;
  localparam int unsigned WB_SEL_BIT      = 1;

  typedef struct packed {
    logic                     lr_en;
    logic                     brx;
    logic [ALU_SEL_W_PKG-1:0] alu_sel;
    logic [BR_SEL_W-1:0]      br_sel;
  } ex_ctrl_t;

  typedef struct packed {
    logic wr_en;
    logic imm_sel;
    logic read;
  } mem_ctrl_t;

  typedef struct packed {
    logic wb_sel;
    logic reg_en;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  localparam int unsigned EX_W  = $bits(ex_ctrl_t);
  localparam int unsigned MEM_W = $bits(mem_ctrl_t);
  localparam int unsigned WB_W  = $bits(wb_ctrl_t);

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipeline_hazard_unit.sv
// Load-use hazard detection between the EX-slot load and the instruction waiting in ID.
module pipeline_hazard_unit
  import pipeline_id_ex_pkg::*;
#(
  parameter int unsigned REG_AW = 2
) (
  input  logic              ex_valid,
  input  logic [MEM_W-1:0]  ex_mem_ctrl,
  input  logic [WB_W-1:0]   ex_wb_ctrl,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic              ra_used,
  input  logic              rb_used,
  output logic              hazard
);

  logic ex_is_load;
  logic src_match;

  always_comb begin
    ex_is_load = ex_valid & ex_mem_ctrl[MEM_READ_BIT] & ex_wb_ctrl[WB_REG_EN_BIT];
    src_match  = (ra_used & (ra == ex_rd)) | (rb_used & (rb == ex_rd));
    hazard     = ex_is_load & id_valid & src_match;
  end

endmodule

// File: rtl/pipeline_id_ex.sv
// ID/EX pipeline register with flush/stall/load-use bubble handling and
// saturating stall/bubble performance counters.
module pipeline_id_ex
  import pipeline_id_ex_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REG_AW    = 2,
  parameter int unsigned ALU_SEL_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] PC2,
  input  logic [DATA_W-1:0] ea,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic [EX_W-1:0]   ex_ctrl,
  input  logic [MEM_W-1:0]  mem_ctrl,
  input  logic [WB_W-1:0]   wb_ctrl,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic [DATA_W-1:0] PC2_out,
  output logic [DATA_W-1:0] ea_out,
  output logic [REG_AW-1:0] ra_out,
  output logic [REG_AW-1:0] rb_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [EX_W-1:0]   ex_ctrl_out,
  output logic [MEM_W-1:0]  mem_ctrl_out,
  output logic [WB_W-1:0]   wb_ctrl_out,
  output logic              valid_out,
  output logic              hazard,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (ALU_SEL_W != ALU_SEL_W_PKG) begin : g_alu_sel_w_check
    $error("ALU_SEL_W must match the control layout in pipeline_id_ex_pkg");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t ctrl_in;
  ctrl_t ctrl_q;
  logic  bubble;
  logic  load;

  always_comb begin
    ctrl_in = ctrl_t'({ex_ctrl, mem_ctrl, wb_ctrl});
    bubble  = flush | (~stall & hazard);
    load    = ~flush & ~stall & ~hazard;
  end

  // A load with id_valid=0 clears the slot exactly like a bubble, but is not counted as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      ctrl_q    <= BUBBLE;
      A_out     <= '0;
      B_out     <= '0;
      PC2_out   <= '0;
      ea_out    <= '0;
      ra_out    <= '0;
      rb_out    <= '0;
      rd_out    <= '0;
    end else if (bubble || (load && !id_valid)) begin
      valid_out <= 1'b0;
      ctrl_q    <= BUBBLE;
      A_out     <= '0;
      B_out     <= '0;
      PC2_out   <= '0;
      ea_out    <= '0;
      ra_out    <= '0;
      rb_out    <= '0;
      rd_out    <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      ctrl_q    <= ctrl_in;
      A_out     <= A;
      B_out     <= B;
      PC2_out   <= PC2;
      ea_out    <= ea;
      ra_out    <= ra;
      rb_out    <= rb;
      rd_out    <= rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  assign ex_ctrl_out  = ctrl_q.ex;
  assign mem_ctrl_out = ctrl_q.mem;
  assign wb_ctrl_out  = ctrl_q.wb;

  pipeline_hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid    (valid_out),
    .ex_mem_ctrl (mem_ctrl_out),
    .ex_wb_ctrl  (wb_ctrl_out),
    .ex_rd       (rd_out),
    .id_valid    (id_valid),
    .ra          (ra),
    .rb          (rb),
    .ra_used     (ra_used),
    .rb_used     (rb_used),
    .hazard      (hazard)
  );

endmodule

// File: tb/tb_pipeline_id_ex.sv
// Self-checking bench for pipeline_id_ex: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the stage register.
module tb_pipeline_id_ex;

  localparam int unsigned PW = 51;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall, flush, id_valid, ra_used, rb_used, cnt_clr;
  logic [7:0] A, B, PC2, ea;
  logic [1:0] ra, rb, rd;
  logic [7:0] ex_ctrl;
  logic [2:0] mem_ctrl;
  logic [1:0] wb_ctrl;

  logic [7:0]  A_out, B_out, PC2_out, ea_out;
  logic [1:0]  ra_out, rb_out, rd_out;
  logic [7:0]  ex_ctrl_out;
  logic [2:0]  mem_ctrl_out;
  logic [1:0]  wb_ctrl_out;
  logic        valid_out, hazard;
  logic [15:0] stall_cnt, bubble_cnt;

  logic [7:0]  d2_A_out, d2_B_out, d2_PC2_out, d2_ea_out;
  logic [1:0]  d2_ra_out, d2_rb_out, d2_rd_out;
  logic [7:0]  d2_ex_ctrl_out;
  logic [2:0]  d2_mem_ctrl_out;
  logic [1:0]  d2_wb_ctrl_out;
  logic        d2_valid_out, d2_hazard;
  logic [1:0]  d2_stall_cnt, d2_bubble_cnt;

  int checks = 0;
  int passed = 0;

  // Behavioural model of the EX slot and of both counter widths
  logic [PW-1:0] m_pay;
  bit            m_valid;
  int unsigned   m_scnt, m_bcnt, m_scnt2, m_bcnt2;

  always #5 clk = ~clk;

  pipeline_id_ex dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .A(A), .B(B), .PC2(PC2), .ea(ea), .ra(ra), .rb(rb), .rd(rd),
    .ra_used(ra_used), .rb_used(rb_used), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .cnt_clr(cnt_clr),
    .A_out(A_out), .B_out(B_out), .PC2_out(PC2_out), .ea_out(ea_out),
    .ra_out(ra_out), .rb_out(rb_out), .rd_out(rd_out), .ex_ctrl_out(ex_ctrl_out),
    .mem_ctrl_out(mem_ctrl_out), .wb_ctrl_out(wb_ctrl_out), .valid_out(valid_out),
    .hazard(hazard), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipeline_id_ex #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .A(A), .B(B), .PC2(PC2), .ea(ea), .ra(ra), .rb(rb), .rd(rd),
    .ra_used(ra_used), .rb_used(rb_used), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .cnt_clr(cnt_clr),
    .A_out(d2_A_out), .B_out(d2_B_out), .PC2_out(d2_PC2_out), .ea_out(d2_ea_out),
    .ra_out(d2_ra_out), .rb_out(d2_rb_out), .rd_out(d2_rd_out), .ex_ctrl_out(d2_ex_ctrl_out),
    .mem_ctrl_out(d2_mem_ctrl_out), .wb_ctrl_out(d2_wb_ctrl_out), .valid_out(d2_valid_out),
    .hazard(d2_hazard), .stall_cnt(d2_stall_cnt), .bubble_cnt(d2_bubble_cnt)
  );

  function automatic logic [PW-1:0] in_vec();
    return {A, B, PC2, ea, ra, rb, rd, ex_ctrl, mem_ctrl, wb_ctrl};
  endfunction

  function automatic logic [PW-1:0] out_vec();
    return {A_out, B_out, PC2_out, ea_out, ra_out, rb_out, rd_out, ex_ctrl_out, mem_ctrl_out, wb_ctrl_out};
  endfunction

  // Model field views: rd at [14:13], mem.read at [2], wb.reg_en at [0]
  function automatic bit model_hazard();
    logic [1:0] mrd;
    mrd = m_pay[14:13];
    return m_valid && m_pay[2] && m_pay[0] && id_valid &&
           ((ra_used && ra == mrd) || (rb_used && rb == mrd));
  endfunction

  function automatic int unsigned sat_inc(int unsigned v, int unsigned max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_pay = '0; m_valid = 0;
    m_scnt = 0; m_bcnt = 0; m_scnt2 = 0; m_bcnt2 = 0;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; id_valid = 0; ra_used = 0; rb_used = 0; cnt_clr = 0;
    A = '0; B = '0; PC2 = '0; ea = '0; ra = '0; rb = '0; rd = '0;
    ex_ctrl = '0; mem_ctrl = '0; wb_ctrl = '0;
  endtask

  task automatic rand_payload();
    A = 8'($urandom); B = 8'($urandom); PC2 = 8'($urandom); ea = 8'($urandom);
    ra = 2'($urandom); rb = 2'($urandom); rd = 2'($urandom);
    ex_ctrl = 8'($urandom); mem_ctrl = 3'($urandom); wb_ctrl = 2'($urandom);
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT
  task automatic tick();
    bit hz;
    bit bub;
    hz  = model_hazard();
    bub = flush || (!stall && hz);
    if (bub) begin
      m_pay = '0; m_valid = 0;
    end else if (!stall) begin
      m_valid = id_valid;
      m_pay   = id_valid ? in_vec() : '0;
    end
    if (cnt_clr) begin
      m_scnt = 0; m_bcnt = 0; m_scnt2 = 0; m_bcnt2 = 0;
    end else begin
      if (stall) begin m_scnt = sat_inc(m_scnt, 65535); m_scnt2 = sat_inc(m_scnt2, 3); end
      if (bub)   begin m_bcnt = sat_inc(m_bcnt, 65535); m_bcnt2 = sat_inc(m_bcnt2, 3); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    model_reset();
    #2;
    checks++; if (out_vec() !== '0) $display("FAIL reset_payload got=%h exp=0", out_vec()); else passed++;
    checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else passed++;
    checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard got=%b exp=0", hazard); else passed++;
    checks++; if ({stall_cnt, bubble_cnt} !== 32'h0) $display("FAIL reset_counters got=%h exp=0", {stall_cnt, bubble_cnt}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_latency();
    set_idle();
    rand_payload();
    id_valid = 1; ra_used = 0; rb_used = 0;
    A = 8'h5A; ex_ctrl = 8'h0C;
    #1;
    checks++; if (valid_out !== 1'b0) $display("FAIL latency_before_edge valid got=%b exp=0", valid_out); else passed++;
    tick();
    checks++; if (A_out !== 8'h5A) $display("FAIL latency_A got=%h exp=5a", A_out); else passed++;
    checks++; if (ex_ctrl_out[5:2] !== 4'h3) $display("FAIL latency_alu_sel got=%h exp=3", ex_ctrl_out[5:2]); else passed++;
    checks++; if (valid_out !== 1'b1) $display("FAIL latency_valid got=%b exp=1", valid_out); else passed++;
    checks++; if (out_vec() !== m_pay) $display("FAIL latency_payload got=%h exp=%h", out_vec(), m_pay); else passed++;
  endtask

  task automatic test_stall_hold();
    logic [PW-1:0] held;
    int unsigned   s0;
    held = out_vec();
    s0   = m_scnt;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      id_valid = 1; stall = 1; ra_used = 1; rb_used = 1;
      tick();
      checks++; if (out_vec() !== held) $display("FAIL stall_hold_payload cyc=%0d got=%h exp=%h", i, out_vec(), held); else passed++;
      checks++; if (valid_out !== 1'b1) $display("FAIL stall_hold_valid cyc=%0d got=%b exp=1", i, valid_out); else passed++;
    end
    stall = 0;
    checks++; if (stall_cnt !== 16'(s0 + 3)) $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 3); else passed++;
  endtask

  task automatic test_load_use();
    int unsigned b0;
    set_idle();
    rand_payload();
    id_valid = 1; mem_ctrl = 3'b001; wb_ctrl = 2'b01; rd = 2'd2;
    tick();
    rand_payload();
    id_valid = 1; ra = 2'd2; ra_used = 1; rb = 2'd0; rb_used = 0;
    #1;
    checks++; if (hazard !== 1'b1) $display("FAIL load_use_hazard got=%b exp=1", hazard); else passed++;
    b0 = m_bcnt;
    tick();
    checks++; if (valid_out !== 1'b0) $display("FAIL load_use_bubble_valid got=%b exp=0", valid_out); else passed++;
    checks++; if (out_vec() !== '0) $display("FAIL load_use_bubble_payload got=%h exp=0", out_vec()); else passed++;
    checks++; if (bubble_cnt !== 16'(b0 + 1)) $display("FAIL load_use_bubble_cnt got=%0d exp=%0d", bubble_cnt, b0 + 1); else passed++;
    checks++; if (hazard !== 1'b0) $display("FAIL load_use_hazard_clears got=%b exp=0", hazard); else passed++;
  endtask

  task automatic test_no_false_hazard();
    for (int v = 0; v < 2; v++) begin
      set_idle();
      rand_payload();
      id_valid = 1; wb_ctrl = 2'b01; rd = 2'd2;
      mem_ctrl = (v == 0) ? 3'b001 : 3'b000;
      tick();
      rand_payload();
      id_valid = 1; ra = 2'd2; rb = 2'd2; rb_used = 0;
      ra_used = (v == 0) ? 1'b0 : 1'b1;
      #1;
      checks++; if (hazard !== 1'b0) $display("FAIL no_false_hazard v=%0d got=%b exp=0", v, hazard); else passed++;
      tick();
      checks++; if ({valid_out, out_vec()} !== {1'b1, m_pay}) $display("FAIL no_false_hazard_load v=%0d got=%h exp=%h", v, {valid_out, out_vec()}, {1'b1, m_pay}); else passed++;
    end
  endtask

  task automatic test_flush_beats_stall();
    int unsigned s0, b0;
    set_idle();
    rand_payload();
    id_valid = 1;
    tick();
    rand_payload();
    id_valid = 1; flush = 1; stall = 1;
    s0 = m_scnt; b0 = m_bcnt;
    tick();
    flush = 0; stall = 0;
    checks++; if ({ex_ctrl_out, mem_ctrl_out, wb_ctrl_out, valid_out} !== 14'h0) $display("FAIL flush_ctrl got=%h exp=0", {ex_ctrl_out, mem_ctrl_out, wb_ctrl_out, valid_out}); else passed++;
    checks++; if (out_vec() !== '0) $display("FAIL flush_payload got=%h exp=0", out_vec()); else passed++;
    checks++; if (bubble_cnt !== 16'(b0 + 1)) $display("FAIL flush_bubble_cnt got=%0d exp=%0d", bubble_cnt, b0 + 1); else passed++;
    checks++; if (stall_cnt !== 16'(s0 + 1)) $display("FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 1); else passed++;
  endtask

  task automatic test_async_reset();
    set_idle();
    rand_payload();
    id_valid = 1; mem_ctrl = 3'b001; wb_ctrl = 2'b01; rd = 2'd1;
    tick();
    rand_payload();
    id_valid = 1; stall = 1; ra = 2'd1; ra_used = 1;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if ({valid_out, out_vec()} !== '0) $display("FAIL async_reset_outputs got=%h exp=0", {valid_out, out_vec()}); else passed++;
    checks++; if ({hazard, stall_cnt, bubble_cnt} !== '0) $display("FAIL async_reset_hazard_cnt got=%h exp=0", {hazard, stall_cnt, bubble_cnt}); else passed++;
    #1;
    rst = 1'b0;
    tick();
    stall = 0;
    checks++; if (valid_out !== 1'b0) $display("FAIL async_reset_discard got=%b exp=0", valid_out); else passed++;
  endtask

  task automatic test_saturation();
    set_idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++; if (d2_stall_cnt !== 2'd0) $display("FAIL sat_clear_start got=%0d exp=0", d2_stall_cnt); else passed++;
    stall = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (d2_stall_cnt !== 2'd3) $display("FAIL sat_stall_cnt got=%0d exp=3", d2_stall_cnt); else passed++;
    cnt_clr = 1;
    tick();
    cnt_clr = 0; stall = 0;
    checks++; if (d2_stall_cnt !== 2'd0) $display("FAIL sat_clr_override got=%0d exp=0", d2_stall_cnt); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL clr_override_wide got=%0d exp=0", stall_cnt); else passed++;
    flush = 1;
    for (int i = 0; i < 5; i++) tick();
    flush = 0;
    checks++; if (d2_bubble_cnt !== 2'd3) $display("FAIL sat_bubble_cnt got=%0d exp=3", d2_bubble_cnt); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      id_valid = ($urandom_range(3) != 0);
      ra_used  = 1'($urandom); rb_used = 1'($urandom);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(7) == 0);
      cnt_clr  = ($urandom_range(15) == 0);
      #1;
      checks++; if (hazard !== model_hazard()) $display("FAIL rand_hazard cyc=%0d got=%b exp=%b", i, hazard, model_hazard()); else passed++;
      tick();
      checks++; if ({valid_out, out_vec()} !== {m_valid, m_pay}) $display("FAIL rand_state cyc=%0d got=%h exp=%h", i, {valid_out, out_vec()}, {m_valid, m_pay}); else passed++;
      checks++; if ({stall_cnt, bubble_cnt, d2_stall_cnt, d2_bubble_cnt} !== {m_scnt[15:0], m_bcnt[15:0], m_scnt2[1:0], m_bcnt2[1:0]}) $display("FAIL rand_counters cyc=%0d got=%h exp=%h", i, {stall_cnt, bubble_cnt, d2_stall_cnt, d2_bubble_cnt}, {m_scnt[15:0], m_bcnt[15:0], m_scnt2[1:0], m_bcnt2[1:0]}); else passed++;
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_stall_hold();
    test_load_use();
    test_no_false_hazard();
    test_flush_beats_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
